imowsum_accum_norm: RTL and testbench

//  Consumer end of the per-neighbour weight stage in over-exposure correction. For each output pixel it

---
 rtl/imowsum_accum_norm.sv | 209 ++++++++++++++++++++
 tb/tb_imowsum_accum_norm.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/imowsum_accum_norm.sv
// Window accumulator and shared-divisor normaliser for the over-exposure
// correction weight stage. Taps stream into per-channel accumulators. At the
// last tap of a window the totals are parked in pending registers, and a
// restoring divider turns each channel sum into sum / weight_sum. It produces
// one quotient bit per clock for all channels at once.
`timescale 1ns/1ps

// Per-channel lane: accumulator, pending sum, restoring-divide datapath.
module imowsum_div_lane #(
  parameter int DW_IN  = 10,
  parameter int DW_DEC = 8,
  parameter int SW     = 19,
  parameter int WW     = 18,
  parameter int NW     = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_en,
  input  logic              acc_last,
  input  logic [DW_IN-1:0]  ch,
  input  logic              load,
  input  logic [WW-1:0]     den,
  input  logic              step,
  input  logic [NW-1:0]     dsh,
  input  logic              fin,
  input  logic              zero,
  output logic [DW_IN-1:0]  pix
);
  logic [SW-1:0]    csum, pcsum, csum_nxt;
  logic [NW-1:0]    rem, num, den_sh;
  logic [DW_IN-2:0] q;
  logic             ovf, ge;

  assign csum_nxt = csum + SW'(ch);
  // Round to nearest: add half the divisor before the floor division.
  assign num      = NW'({pcsum, DW_DEC'(0)}) + NW'(den >> 1);
  assign den_sh   = NW'({den, DW_IN'(0)});
  assign ge       = (rem >= dsh);

  // Running channel sum; the window total moves to pcsum on the last tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum  <= '0;
      pcsum <= '0;
    end else if (acc_en) begin
      if (acc_last) begin
        pcsum <= csum_nxt;
        csum  <= '0;
      end else begin
        csum  <= csum_nxt;
      end
    end
  end

  // Restoring divide: load the numerator, then one compare/subtract per step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      ovf <= 1'b0;
      q   <= '0;
    end else if (load) begin
      rem <= num;
      ovf <= (num >= den_sh);
      q   <= '0;
    end else if (step) begin
      if (ge) rem <= rem - dsh;
      q <= {q[DW_IN-3:0], ge};
    end
  end

  // Result register: updated only on the finishing edge, so it holds through HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pix <= '0;
    else if (fin)  pix <= zero ? '0 : (ovf ? '1 : {q, ge});
  end
endmodule

module imowsum_accum_norm #(
  parameter int DW_IN    = 10,
  parameter int DW_DEC   = 8,
  parameter int MAX_TAPS = 325
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                part_vld,
  input  logic                part_last,
  input  logic [DW_DEC:0]     wtmp,
  input  logic [4*DW_IN-1:0]  imosum_part,
  output logic                in_rdy,
  output logic [4*DW_IN-1:0]  pix_out,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic                div0,
  output logic                tap_err
);
  localparam int NCH  = 4;
  localparam int CW   = $clog2(MAX_TAPS+1);
  localparam int WW   = DW_DEC + 1 + CW;
  localparam int SW   = DW_IN + CW;
  localparam int NW   = (SW + DW_DEC + 1 > WW + DW_IN) ? SW + DW_DEC + 1 : WW + DW_IN;
  localparam int CNTW = $clog2(DW_IN+1);

  typedef enum logic [1:0] {IDLE, DIV, HOLD} state_t;

  state_t                     state;
  logic [WW-1:0]              wsum, pwsum, wsum_nxt;
  logic [CW-1:0]              tap_cnt, tap_nxt;
  logic                       pend_vld, pterr, terr_nxt, acc, load, fin, step;
  logic [NW-1:0]              dsh;
  logic [CNTW-1:0]            cnt;
  logic                       zdiv, op_terr;
  logic [NCH-1:0][DW_IN-1:0]  part_ch, pix_q;

  assign part_ch  = imosum_part;
  assign pix_out  = pix_q;
  assign in_rdy   = !pend_vld;
  assign acc      = part_vld && !pend_vld;
  assign wsum_nxt = wsum + WW'(wtmp);
  assign tap_nxt  = (tap_cnt == '1) ? tap_cnt : tap_cnt + CW'(1);
  assign terr_nxt = (tap_nxt == '0) || (tap_nxt > CW'(MAX_TAPS));
  assign load     = (state == IDLE) && pend_vld;
  // A zero divisor ends DIV on its first edge with a forced zero result.
  assign fin      = (state == DIV) && (zdiv || cnt == CNTW'(DW_IN));
  assign step     = (state == DIV) && !zdiv;

  // Weight sum and tap count; window totals park in pending regs on the last tap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wsum    <= '0;
      pwsum   <= '0;
      tap_cnt <= '0;
      pterr   <= 1'b0;
    end else if (acc) begin
      if (part_last) begin
        pwsum   <= wsum_nxt;
        pterr   <= terr_nxt;
        wsum    <= '0;
        tap_cnt <= '0;
      end else begin
        wsum    <= wsum_nxt;
        tap_cnt <= tap_nxt;
      end
    end
  end

  // Pending flag: a new window landing beats the divider's consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 pend_vld <= 1'b0;
    else if (acc && part_last)  pend_vld <= 1'b1;
    else if (load)              pend_vld <= 1'b0;
  end

  // Divider control: IDLE -> DIV (DW_IN+1 steps) -> HOLD until handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dsh     <= '0;
      cnt     <= '0;
      zdiv    <= 1'b0;
      op_terr <= 1'b0;
      out_vld <= 1'b0;
      div0    <= 1'b0;
      tap_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pend_vld) begin
          dsh     <= NW'({pwsum, DW_IN'(0)});
          zdiv    <= (pwsum == '0);
          op_terr <= pterr;
          cnt     <= '0;
          state   <= DIV;
        end
        DIV: if (fin) begin
          state   <= HOLD;
          out_vld <= 1'b1;
          div0    <= zdiv;
          tap_err <= op_terr;
        end else begin
          dsh <= dsh >> 1;
          cnt <= cnt + CNTW'(1);
        end
        HOLD: if (out_rdy) begin
          out_vld <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    imowsum_div_lane #(
      .DW_IN(DW_IN), .DW_DEC(DW_DEC), .SW(SW), .WW(WW), .NW(NW)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .acc_en   (acc),
      .acc_last (part_last),
      .ch       (part_ch[k]),
      .load     (load),
      .den      (pwsum),
      .step     (step),
      .dsh      (dsh),
      .fin      (fin),
      .zero     (zdiv),
      .pix      (pix_q[k])
    );
  end
endmodule

// File: tb/tb_imowsum_accum_norm.sv
// Bench for imowsum_accum_norm: directed vector table, backpressure and
// mid-divide reset sequences, then random windows checked against an
// arithmetic reference model through an expected-output queue.
`timescale 1ns/1ps

module tb_imowsum_accum_norm;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        part_vld, part_last, out_rdy;
  logic [8:0]  wtmp;
  logic [39:0] imosum_part;
  logic        in_rdy, out_vld, div0, tap_err;
  logic [39:0] pix_out;

  imowsum_accum_norm dut (
    .clk(clk), .rst_n(rst_n), .part_vld(part_vld), .part_last(part_last),
    .wtmp(wtmp), .imosum_part(imosum_part), .in_rdy(in_rdy), .pix_out(pix_out),
    .out_vld(out_vld), .out_rdy(out_rdy), .div0(div0), .tap_err(tap_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [39:0] pix; logic d0; logic te; } exp_t;
  typedef struct { int ntaps; int w; logic [39:0] part; logic [39:0] epix; bit d0; bit te; int lat; } vec_t;

  exp_t    expq[$];
  vec_t    vt[8];
  int      n_cmp = 0, n_err = 0;
  longint  m_w, m_n;
  longint  m_c[4];
  bit      rnd_done;

  function automatic logic [39:0] mk(int c3, int c2, int c1, int c0);
    logic [9:0] a3, a2, a1, a0;
    a3 = 10'(c3); a2 = 10'(c2); a1 = 10'(c1); a0 = 10'(c0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic check(string name, longint act, longint expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic model_clear();
    m_w = 0; m_n = 0;
    for (int k = 0; k < 4; k++) m_c[k] = 0;
  endtask

  // Reference: plain integer sums, rounded division, saturation at 1023.
  task automatic model_tap(int w, logic [39:0] part, bit last);
    exp_t e;
    longint num, q;
    m_w += w; m_n++;
    for (int k = 0; k < 4; k++) m_c[k] += part[k*10 +: 10];
    if (last) begin
      e.pix = '0;
      for (int k = 0; k < 4; k++) begin
        if (m_w == 0) q = 0;
        else begin
          num = m_c[k] * 256 + m_w / 2;
          q = num / m_w;
          if (q > 1023) q = 1023;
        end
        e.pix[k*10 +: 10] = 10'(q);
      end
      e.d0 = (m_w == 0);
      e.te = (m_n > 325);
      expq.push_back(e);
      model_clear();
    end
  endtask

  // Called at posedge+1; waits for in_rdy (bounded), presents one tap for one edge.
  task automatic send_tap(int w, logic [39:0] part, bit last);
    int guard = 0;
    while (!in_rdy && guard < 500) begin @(posedge clk); #1; guard++; end
    if (!in_rdy) begin
      check("in_rdy timeout", 0, 1);
    end else begin
      part_vld = 1'b1; wtmp = 9'(w); imosum_part = part; part_last = last;
      @(posedge clk); #1;
      model_tap(w, part, last);
      part_vld = 1'b0; part_last = 1'b0;
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_vld && lat < 40) begin @(posedge clk); #1; lat++; end
  endtask

  initial begin
    #3000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, lp;
    rst_n = 1'b0; part_vld = 1'b0; part_last = 1'b0; wtmp = '0; imosum_part = '0; out_rdy = 1'b1;
    model_clear();

    vt[0] = '{1,   256, mk(500,0,1023,7),     mk(500,0,1023,7),     1'b0, 1'b0, 12};
    vt[1] = '{4,   128, mk(0,0,0,250),        mk(0,0,0,500),        1'b0, 1'b0, 12};
    vt[2] = '{3,   0,   mk(0,0,0,0),          mk(0,0,0,0),          1'b1, 1'b0, 2};
    vt[3] = '{1,   1,   mk(0,0,0,1023),       mk(0,0,0,1023),       1'b0, 1'b0, 12};
    vt[4] = '{2,   256, mk(100,200,300,400),  mk(100,200,300,400),  1'b0, 1'b0, 12};
    vt[5] = '{1,   300, mk(10,20,30,40),      mk(9,17,26,34),       1'b0, 1'b0, 12};
    vt[6] = '{325, 1,   mk(1,1,1,1),          mk(256,256,256,256),  1'b0, 1'b0, 12};
    vt[7] = '{326, 1,   mk(1,1,1,1),          mk(256,256,256,256),  1'b0, 1'b1, 12};

    repeat (3) @(posedge clk);
    #1;
    check("reset out_vld", out_vld, 0);
    check("reset pix_out", pix_out, 0);
    check("reset in_rdy",  in_rdy,  1);
    check("reset div0",    div0,    0);
    check("reset tap_err", tap_err, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Output monitor: every handshake must match the model queue head.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && out_vld && out_rdy) begin
          if (expq.size() == 0) check("spurious out_vld", 1, 0);
          else begin
            exp_t e;
            e = expq.pop_front();
            check("model pix_out", pix_out, e.pix);
            check("model div0",    div0,    e.d0);
            check("model tap_err", tap_err, e.te);
          end
        end
      end
    join_none

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < vt[i].ntaps; j++) send_tap(vt[i].w, vt[i].part, j == vt[i].ntaps - 1);
      wait_out(lat);
      check($sformatf("vec%0d latency", i), lat, vt[i].lat);
      check($sformatf("vec%0d pix_out", i), pix_out, vt[i].epix);
      check($sformatf("vec%0d div0", i),    div0,    vt[i].d0);
      check($sformatf("vec%0d tap_err", i), tap_err, vt[i].te);
      @(posedge clk); #1;
    end

    // Backpressure: three back-to-back windows with out_rdy low.
    out_rdy = 1'b0;
    send_tap(256, mk(1,2,3,4), 1'b1);
    send_tap(256, mk(5,6,7,8), 1'b1);
    check("bp in_rdy low", in_rdy, 0);
    fork
      send_tap(256, mk(9,10,11,12), 1'b1);
      begin
        repeat (20) @(posedge clk);
        #1;
        check("bp out_vld held", out_vld, 1);
        check("bp first pix",    pix_out, mk(1,2,3,4));
        check("bp in_rdy still low", in_rdy, 0);
        out_rdy = 1'b1;
      end
    join
    lp = 0;
    while (expq.size() != 0 && lp < 200) begin @(posedge clk); #1; lp++; end
    check("bp drain", expq.size(), 0);
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of a divide, with a partial next window in flight.
    send_tap(256, mk(100,200,300,400), 1'b1);
    send_tap(100, mk(9,9,9,9), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("pre-reset out_vld", out_vld, 0);
    rst_n = 1'b0;
    #1;
    expq.delete();
    model_clear();
    check("abort out_vld", out_vld, 0);
    check("abort pix_out", pix_out, 0);
    check("abort in_rdy",  in_rdy,  1);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send_tap(256, mk(11,22,33,44), 1'b1);
    wait_out(lat);
    check("post-reset latency", lat, 12);
    check("post-reset pix", pix_out, mk(11,22,33,44));
    check("post-reset div0", div0, 0);
    @(posedge clk); #1;

    // Random windows with random gaps and random out_rdy.
    rnd_done = 1'b0;
    fork
      while (!rnd_done) begin
        @(posedge clk); #1;
        out_rdy = ($urandom_range(3) != 0);
      end
    join_none
    for (int i = 0; i < 60; i++) begin
      int  nt;
      bit  zw;
      nt = $urandom_range(5, 1);
      zw = ($urandom_range(7) == 0);
      for (int j = 0; j < nt; j++) begin
        repeat ($urandom_range(2)) begin @(posedge clk); #1; end
        send_tap(zw ? 0 : $urandom_range(511),
                 mk($urandom_range(1023), $urandom_range(1023), $urandom_range(1023), $urandom_range(1023)),
                 j == nt - 1);
      end
    end
    rnd_done = 1'b1;
    @(posedge clk); #2;
    out_rdy = 1'b1;
    lp = 0;
    while (expq.size() != 0 && lp < 2000) begin @(posedge clk); #1; lp++; end
    check("random drain", expq.size(), 0);
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
